// File: rtl/sync_debounce_pkg.sv
// Shared constants, counter-width helper and per-channel status bundle for the
// multi-channel synchroniser/debouncer. Optional macro: MCSD_HOLD_DETECT_EN.
package sync_debounce_pkg;

  localparam int DEF_CHANNELS        = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 3;
  localparam int DEF_HOLD_CYCLES     = 1000;

  // Bits needed to hold the values 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
`ifdef MCSD_HOLD_DETECT_EN
    logic hold;
`endif
  } chan_status_t;

endpackage

// File: rtl/debounce_channel.sv
// One channel: synchroniser chain, debounce counter, registered edge pulses and,
// with MCSD_HOLD_DETECT_EN defined, a long-press hold counter.
module debounce_channel
  import sync_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_LEVEL     = 1'b0
`ifdef MCSD_HOLD_DETECT_EN
  ,
  parameter int   HOLD_CYCLES     = DEF_HOLD_CYCLES
`endif
) (
  input  logic         control_clock,
  input  logic         control_reset_n,
  input  logic         sample_tick,
  input  logic         raw_in,
  output chan_status_t status
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  chan_status_t           status_q, status_d;
  logic                   synced;

`ifdef MCSD_HOLD_DETECT_EN
  localparam int                HOLD_W   = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
    synced   = sync_q[SYNC_STAGES-1];
    cnt_d    = cnt_q;
    status_d = status_q;

    // Any sample agreeing with the current level restarts qualification.
    if (synced == status_q.level) begin
      cnt_d = '0;
    end else if (sample_tick) begin
      if (cnt_q == CNT_LAST) begin
        status_d.level = synced;
        cnt_d          = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    status_d.rise = status_d.level & ~status_q.level;
    status_d.fall = ~status_d.level & status_q.level;

`ifdef MCSD_HOLD_DETECT_EN
    // Counting starts the tick after the rise; a fall clears alongside its pulse.
    hold_cnt_d = hold_cnt_q;
    if (!status_d.level) begin
      hold_cnt_d = '0;
    end else if (status_q.level && sample_tick && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
    status_d.hold = (hold_cnt_d == HOLD_MAX);
`endif
  end

  always_ff @(posedge control_clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      sync_q         <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q          <= '0;
      status_q       <= '0;
      status_q.level <= RESET_LEVEL;
`ifdef MCSD_HOLD_DETECT_EN
      hold_cnt_q     <= '0;
`endif
    end else begin
      sync_q         <= sync_d;
      cnt_q          <= cnt_d;
      status_q       <= status_d;
`ifdef MCSD_HOLD_DETECT_EN
      hold_cnt_q     <= hold_cnt_d;
`endif
    end
  end

  assign status = status_q;

endmodule

// File: rtl/multi_channel_sync_debounce.sv
// N-channel synchroniser + debouncer with registered rise/fall pulses.
// Optional macro MCSD_HOLD_DETECT_EN adds the HOLD_CYCLES parameter and hold_data port.
module multi_channel_sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int                  CHANNELS        = DEF_CHANNELS,
  parameter int                  SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [CHANNELS-1:0] RESET_VALUE     = '0
`ifdef MCSD_HOLD_DETECT_EN
  ,
  parameter int                  HOLD_CYCLES     = DEF_HOLD_CYCLES
`endif
) (
  input  logic                control_clock,
  input  logic                control_reset_n,
  input  logic                sample_tick,
  input  logic [CHANNELS-1:0] input_data,
  output logic [CHANNELS-1:0] output_data,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
`ifdef MCSD_HOLD_DETECT_EN
  ,
  output logic [CHANNELS-1:0] hold_data
`endif
);

  chan_status_t status [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_VALUE[i])
`ifdef MCSD_HOLD_DETECT_EN
      ,
      .HOLD_CYCLES     (HOLD_CYCLES)
`endif
    ) u_chan (
      .control_clock   (control_clock),
      .control_reset_n (control_reset_n),
      .sample_tick     (sample_tick),
      .raw_in          (input_data[i]),
      .status          (status[i])
    );

    assign output_data[i] = status[i].level;
    assign rise_pulse[i]  = status[i].rise;
    assign fall_pulse[i]  = status[i].fall;
`ifdef MCSD_HOLD_DETECT_EN
    assign hold_data[i]   = status[i].hold;
`endif
  end

endmodule

// File: tb/tb_multi_channel_sync_debounce.sv
// Directed bench for multi_channel_sync_debounce: a default instance and one with
// RESET_VALUE=4'b0101; hold checks compile in with MCSD_HOLD_DETECT_EN.
module tb_multi_channel_sync_debounce;

  logic       clk = 1'b0;
  logic       rst_n, rst_rv_n;
  logic       tick;
  logic [3:0] in_d, in_rv;
  logic [3:0] out_d, rise_d, fall_d;
  logic [3:0] out_rv, rise_rv, fall_rv;
`ifdef MCSD_HOLD_DETECT_EN
  logic [3:0] hold_d, hold_rv;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_channel_sync_debounce #(
    .CHANNELS (4)
`ifdef MCSD_HOLD_DETECT_EN
    ,
    .HOLD_CYCLES (10)
`endif
  ) dut (
    .control_clock   (clk),
    .control_reset_n (rst_n),
    .sample_tick     (tick),
    .input_data      (in_d),
    .output_data     (out_d),
    .rise_pulse      (rise_d),
    .fall_pulse      (fall_d)
`ifdef MCSD_HOLD_DETECT_EN
    ,
    .hold_data       (hold_d)
`endif
  );

  multi_channel_sync_debounce #(
    .CHANNELS    (4),
    .RESET_VALUE (4'b0101)
`ifdef MCSD_HOLD_DETECT_EN
    ,
    .HOLD_CYCLES (10)
`endif
  ) dut_rv (
    .control_clock   (clk),
    .control_reset_n (rst_rv_n),
    .sample_tick     (tick),
    .input_data      (in_rv),
    .output_data     (out_rv),
    .rise_pulse      (rise_rv),
    .fall_pulse      (fall_rv)
`ifdef MCSD_HOLD_DETECT_EN
    ,
    .hold_data       (hold_rv)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply a new input word and expect the level change plus pulses exactly 5 clocks later.
  task automatic run_edge(input string tag, input bit use_rv, input logic [3:0] new_in,
                          input logic [3:0] prev_out, input logic [3:0] new_out,
                          input logic [3:0] exp_rise, input logic [3:0] exp_fall);
    logic [3:0] o, r, f;
    if (use_rv) in_rv = new_in;
    else        in_d  = new_in;
    for (int k = 1; k <= 6; k++) begin
      step();
      o = use_rv ? out_rv  : out_d;
      r = use_rv ? rise_rv : rise_d;
      f = use_rv ? fall_rv : fall_d;
      chk({tag, "_out"},  o, (k >= 5) ? new_out : prev_out);
      chk({tag, "_rise"}, r, (k == 5) ? exp_rise : 4'b0000);
      chk({tag, "_fall"}, f, (k == 5) ? exp_fall : 4'b0000);
    end
  endtask

  initial begin
    logic [11:0] bounce;
    rst_n    = 1'b0;
    rst_rv_n = 1'b0;
    tick     = 1'b1;
    in_d     = 4'b0000;
    in_rv    = 4'b0101;
    step(); step(); step();
    chk("rst_out",    out_d,  4'b0000);
    chk("rst_rv_out", out_rv, 4'b0101);
    chk("rst_rv_rise", rise_rv, 4'b0000);
    chk("rst_rv_fall", fall_rv, 4'b0000);
    rst_n    = 1'b1;
    rst_rv_n = 1'b1;

    // Reset release with inputs matching RESET_VALUE: quiet for 20 cycles.
    for (int k = 0; k < 20; k++) begin
      step();
      chk("rel_rv_out",  out_rv,  4'b0101);
      chk("rel_rv_rise", rise_rv, 4'b0000);
      chk("rel_rv_fall", fall_rv, 4'b0000);
    end
    chk("rel_out", out_d, 4'b0000);

    run_edge("clean_rise", 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

    // Two-cycle highs on channel 1 never qualify.
    bounce = 12'b0000_0011_0011;
    for (int k = 0; k < 12; k++) begin
      in_d[1] = bounce[k];
      step();
      chk("bounce_out",  out_d,  4'b0001);
      chk("bounce_rise", rise_d, 4'b0000);
      chk("bounce_fall", fall_d, 4'b0000);
    end
    run_edge("bounce_settle", 1'b0, 4'b0011, 4'b0001, 4'b0011, 4'b0010, 4'b0000);

    // Tick every 4th clock: synced at clock 2, ticks at 4/8/12, accepted at 12.
    in_d = 4'b0111;
    for (int k = 1; k <= 14; k++) begin
      tick = (k % 4 == 0);
      step();
      chk("tick_out",  out_d,  (k >= 12) ? 4'b0111 : 4'b0011);
      chk("tick_rise", rise_d, (k == 12) ? 4'b0100 : 4'b0000);
    end
    tick = 1'b1;

    run_edge("multi_prep", 1'b0, 4'b0110, 4'b0111, 4'b0110, 4'b0000, 4'b0001);
    run_edge("multi",      1'b0, 4'b1011, 4'b0110, 4'b1011, 4'b1001, 4'b0100);

    // Reset while channel 1 of dut_rv is mid-qualification (counter at 2).
    in_rv = 4'b0111;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("midq_out", out_rv, 4'b0101);
    end
    rst_rv_n = 1'b0;
    #1;
    chk("midq_rst_out",  out_rv,  4'b0101);
    chk("midq_rst_rise", rise_rv, 4'b0000);
    step();
    rst_rv_n = 1'b1;
    run_edge("midq_after", 1'b1, 4'b0111, 4'b0101, 4'b0111, 4'b0010, 4'b0000);

`ifdef MCSD_HOLD_DETECT_EN
    run_edge("hold_rise", 1'b0, 4'b1111, 4'b1011, 4'b1111, 4'b0100, 4'b0000);
    chk("hold_pre", hold_d[2], 1'b0);
    for (int k = 2; k <= 10; k++) begin
      step();
      chk("hold_cnt", hold_d[2], (k == 10));
    end
    in_d = 4'b1011;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("hold_rel",      hold_d[2], (k < 5));
      chk("hold_rel_fall", fall_d,    (k == 5) ? 4'b0100 : 4'b0000);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
